// File: rtl/mem_access_unit_if.sv
// MEM-stage inputs, data-memory bus and MEM/WB outputs of the memory access unit.
// The slave modport is the unit itself; the master modport is whoever drives it.
interface mem_access_unit_if #(
  parameter int RF_SRC_W = 2
);
  logic [31:0]         mem_inst;
  logic [31:0]         mem_opResult;
  logic [31:0]         mem_memData;
  logic                mem_memWE;
  logic                mem_memRE;
  logic                mem_rfWE;
  logic [4:0]          mem_rfDst;
  logic [RF_SRC_W-1:0] mem_rfSrc;
  logic                mem_stall;

  logic                dmem_req;
  logic                dmem_we;
  logic [31:0]         dmem_addr;
  logic [31:0]         dmem_wdata;
  logic [3:0]          dmem_be;
  logic                dmem_ack;
  logic [31:0]         dmem_rdata;

  logic [31:0]         wb_inst;
  logic [31:0]         wb_opResult;
  logic [31:0]         wb_memOut;
  logic                wb_rfWE;
  logic [4:0]          wb_rfDst;
  logic [RF_SRC_W-1:0] wb_rfSrc;
  logic                wb_addrErr;
  logic                wb_busErr;

  modport slave (
    input  mem_inst, mem_opResult, mem_memData, mem_memWE, mem_memRE,
           mem_rfWE, mem_rfDst, mem_rfSrc, dmem_ack, dmem_rdata,
    output mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           wb_inst, wb_opResult, wb_memOut, wb_rfWE, wb_rfDst, wb_rfSrc,
           wb_addrErr, wb_busErr
  );

  modport master (
    output mem_inst, mem_opResult, mem_memData, mem_memWE, mem_memRE,
           mem_rfWE, mem_rfDst, mem_rfSrc, dmem_ack, dmem_rdata,
    input  mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           wb_inst, wb_opResult, wb_memOut, wb_rfWE, wb_rfDst, wb_rfSrc,
           wb_addrErr, wb_busErr
  );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory access (byte/half/word loads and stores over req/ack) and the MEM/WB
// pipeline register, with upstream stall while memory is busy and timeout abort.
//
// state | meaning
// IDLE  | no access outstanding; an aligned access requests combinationally
// WAIT  | request outstanding, counting cycles toward the timeout abort
module mem_access_unit #(
  parameter int TIMEOUT  = 16,
  parameter int RF_SRC_W = 2
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam int              CNT_W    = ($clog2(TIMEOUT) > 5) ? $clog2(TIMEOUT) : 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;

  logic [31:0]         r_wb_inst;
  logic [31:0]         r_wb_opResult;
  logic [31:0]         r_wb_memOut;
  logic                r_wb_rfWE;
  logic [4:0]          r_wb_rfDst;
  logic [RF_SRC_W-1:0] r_wb_rfSrc;
  logic                r_wb_addrErr;
  logic                r_wb_busErr;

  logic [5:0]  w_opcode;
  logic [1:0]  w_lane;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_signed;
  logic        w_access;
  logic        w_load;
  logic        w_misalign;
  logic        w_go;
  logic        w_req;
  logic        w_abort;
  logic        w_stall;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic [7:0]  w_rbyte;
  logic [15:0] w_rhalf;
  logic [31:0] w_load_data;

  always_comb begin
    w_opcode   = bus.mem_inst[31:26];
    w_lane     = bus.mem_opResult[1:0];
    w_is_byte  = (w_opcode == OP_LB) || (w_opcode == OP_LBU) || (w_opcode == OP_SB);
    w_is_half  = (w_opcode == OP_LH) || (w_opcode == OP_LHU) || (w_opcode == OP_SH);
    w_signed   = (w_opcode == OP_LB) || (w_opcode == OP_LH);
    w_access   = bus.mem_memRE | bus.mem_memWE;
    // store wins when both enables are set
    w_load     = bus.mem_memRE & ~bus.mem_memWE;
    w_misalign = 1'b0;
    if (w_access) begin
      if (w_is_half)      w_misalign = w_lane[0];
      else if (!w_is_byte) w_misalign = (w_lane != 2'b00);
    end
    w_go = w_access & ~w_misalign;
  end

  always_comb begin
    w_req   = ~rst & (((r_state == S_IDLE) & w_go) | (r_state == S_WAIT));
    w_abort = (r_state == S_WAIT) & (r_cnt == CNT_LAST) & ~bus.dmem_ack;
    w_stall = w_req & ~bus.dmem_ack & ~w_abort;
  end

  always_comb begin
    w_wdata = bus.mem_memData;
    w_be    = 4'b1111;
    if (bus.mem_memWE) begin
      if (w_is_byte) begin
        w_wdata = {4{bus.mem_memData[7:0]}};
        w_be    = 4'b0001 << w_lane;
      end else if (w_is_half) begin
        w_wdata = {2{bus.mem_memData[15:0]}};
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
      end
    end
  end

  always_comb begin
    case (w_lane)
      2'd0:    w_rbyte = bus.dmem_rdata[7:0];
      2'd1:    w_rbyte = bus.dmem_rdata[15:8];
      2'd2:    w_rbyte = bus.dmem_rdata[23:16];
      default: w_rbyte = bus.dmem_rdata[31:24];
    endcase
    w_rhalf = w_lane[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    if (w_is_byte)
      w_load_data = {{24{w_signed & w_rbyte[7]}}, w_rbyte};
    else if (w_is_half)
      w_load_data = {{16{w_signed & w_rhalf[15]}}, w_rhalf};
    else
      w_load_data = bus.dmem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && !bus.dmem_ack) begin
            r_state <= S_WAIT;
            r_cnt   <= CNT_W'(1);
          end
        end
        default: begin
          if (bus.dmem_ack || w_abort) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // A stall pushes a bubble into WB while the MEM register holds the access.
  always_ff @(posedge clk) begin
    if (rst || w_stall) begin
      r_wb_inst     <= '0;
      r_wb_opResult <= '0;
      r_wb_memOut   <= '0;
      r_wb_rfWE     <= 1'b0;
      r_wb_rfDst    <= '0;
      r_wb_rfSrc    <= '0;
      r_wb_addrErr  <= 1'b0;
      r_wb_busErr   <= 1'b0;
    end else begin
      r_wb_inst     <= bus.mem_inst;
      r_wb_opResult <= bus.mem_opResult;
      r_wb_rfDst    <= bus.mem_rfDst;
      r_wb_rfSrc    <= bus.mem_rfSrc;
      r_wb_addrErr  <= w_misalign;
      r_wb_busErr   <= w_abort;
      r_wb_rfWE     <= bus.mem_rfWE & ~w_misalign & ~w_abort;
      r_wb_memOut   <= (w_load && w_go && bus.dmem_ack) ? w_load_data : 32'h0;
    end
  end

  assign bus.mem_stall   = w_stall;
  assign bus.dmem_req    = w_req;
  assign bus.dmem_we     = bus.mem_memWE;
  assign bus.dmem_addr   = {bus.mem_opResult[31:2], 2'b00};
  assign bus.dmem_wdata  = w_wdata;
  assign bus.dmem_be     = w_be;
  assign bus.wb_inst     = r_wb_inst;
  assign bus.wb_opResult = r_wb_opResult;
  assign bus.wb_memOut   = r_wb_memOut;
  assign bus.wb_rfWE     = r_wb_rfWE;
  assign bus.wb_rfDst    = r_wb_rfDst;
  assign bus.wb_rfSrc    = r_wb_rfSrc;
  assign bus.wb_addrErr  = r_wb_addrErr;
  assign bus.wb_busErr   = r_wb_busErr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with TIMEOUT=4: extension, store lanes,
// wait states, misalignment, timeout abort, ack-at-timeout and reset mid-access.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mem_access_unit_if #(.RF_SRC_W(2)) bus ();

  mem_access_unit #(.TIMEOUT(4), .RF_SRC_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic re, input logic we, input logic rfwe,
                        input logic [4:0] dst, input logic [1:0] src);
    bus.mem_inst     = {op, 26'h0ABCDE};
    bus.mem_opResult = addr;
    bus.mem_memData  = data;
    bus.mem_memRE    = re;
    bus.mem_memWE    = we;
    bus.mem_rfWE     = rfwe;
    bus.mem_rfDst    = dst;
    bus.mem_rfSrc    = src;
  endtask

  task automatic test_reset();
    set_in(6'h23, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd1, 2'd1);
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
    rst = 1'b1;
    step(); step();
    checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.dmem_req); end
    checks++; if (bus.mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.mem_stall); end
    checks++; if (bus.wb_inst !== 32'h0 || bus.wb_memOut !== 32'h0 || bus.wb_rfWE !== 1'b0 ||
                  bus.wb_busErr !== 1'b0 || bus.wb_addrErr !== 1'b0)
      begin errors++; $display("FAIL reset_wb: inst=%h memOut=%h rfWE=%b want all 0", bus.wb_inst, bus.wb_memOut, bus.wb_rfWE); end
    rst = 1'b0;
    set_in(6'h00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
    step();
  endtask

  task automatic test_load_ext();
    logic [5:0]  ops  [4] = '{6'h20, 6'h24, 6'h21, 6'h25};
    logic [31:0] adrs [4] = '{32'h1003, 32'h1003, 32'h1002, 32'h1000};
    logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_1234};
    for (int i = 0; i < 4; i++) begin
      set_in(ops[i], adrs[i], 32'h0, 1'b1, 1'b0, 1'b1, 5'd7, 2'd1);
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h80FF_1234;
      #1;
      checks++; if (bus.mem_stall !== 1'b0 || bus.dmem_req !== 1'b1)
        begin errors++; $display("FAIL load%0d_req: stall=%b req=%b want 0/1", i, bus.mem_stall, bus.dmem_req); end
      checks++; if (bus.dmem_addr !== 32'h1000 || bus.dmem_be !== 4'b1111 || bus.dmem_we !== 1'b0)
        begin errors++; $display("FAIL load%0d_bus: addr=%h be=%b we=%b want 1000/1111/0", i, bus.dmem_addr, bus.dmem_be, bus.dmem_we); end
      step();
      checks++; if (bus.wb_memOut !== exps[i])
        begin errors++; $display("FAIL load%0d_memOut: got %h want %h", i, bus.wb_memOut, exps[i]); end
      checks++; if (bus.wb_rfWE !== 1'b1 || bus.wb_rfDst !== 5'd7 || bus.wb_opResult !== adrs[i])
        begin errors++; $display("FAIL load%0d_ctl: rfWE=%b dst=%0d op=%h", i, bus.wb_rfWE, bus.wb_rfDst, bus.wb_opResult); end
    end
    bus.dmem_ack = 1'b0;
  endtask

  task automatic test_store();
    logic [5:0]  ops  [3] = '{6'h29, 6'h28, 6'h2B};
    logic [31:0] adrs [3] = '{32'h2002, 32'h2001, 32'h2004};
    logic [31:0] dats [3] = '{32'h1234_ABCD, 32'h0000_005A, 32'h1122_3344};
    logic [31:0] wds  [3] = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'h1122_3344};
    logic [3:0]  bes  [3] = '{4'b1100, 4'b0010, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      set_in(ops[i], adrs[i], dats[i], 1'b0, 1'b1, 1'b0, 5'd0, 2'd0);
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
      #1;
      checks++; if (bus.dmem_wdata !== wds[i] || bus.dmem_be !== bes[i] || bus.dmem_we !== 1'b1)
        begin errors++; $display("FAIL store%0d_bus: wdata=%h be=%b we=%b want %h/%b/1", i, bus.dmem_wdata, bus.dmem_be, bus.dmem_we, wds[i], bes[i]); end
      checks++; if (bus.mem_stall !== 1'b0) begin errors++; $display("FAIL store%0d_stall: got %b want 0", i, bus.mem_stall); end
      step();
      checks++; if (bus.wb_rfWE !== 1'b0 || bus.wb_memOut !== 32'h0)
        begin errors++; $display("FAIL store%0d_wb: rfWE=%b memOut=%h want 0/0", i, bus.wb_rfWE, bus.wb_memOut); end
    end
    bus.dmem_ack = 1'b0;
  endtask

  task automatic test_wait_load();
    int n = 0;
    set_in(6'h23, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 5'd3, 2'd2);
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.mem_stall === 1'b1) n++;
      checks++; if (bus.dmem_addr !== 32'h10 || bus.dmem_req !== 1'b1)
        begin errors++; $display("FAIL wait%0d_bus: addr=%h req=%b want 10/1", i, bus.dmem_addr, bus.dmem_req); end
      step();
      checks++; if (bus.wb_inst !== 32'h0 || bus.wb_rfWE !== 1'b0)
        begin errors++; $display("FAIL wait%0d_bubble: inst=%h rfWE=%b want 0/0", i, bus.wb_inst, bus.wb_rfWE); end
    end
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (n != 3 || bus.mem_stall !== 1'b0)
      begin errors++; $display("FAIL wait_stall_cycles: got %0d (ack-cycle stall=%b) want 3/0", n, bus.mem_stall); end
    step();
    checks++; if (bus.wb_memOut !== 32'hDEAD_BEEF || bus.wb_rfWE !== 1'b1 || bus.wb_rfSrc !== 2'd2)
      begin errors++; $display("FAIL wait_result: memOut=%h rfWE=%b src=%0d want DEADBEEF/1/2", bus.wb_memOut, bus.wb_rfWE, bus.wb_rfSrc); end
    bus.dmem_ack = 1'b0;
  endtask

  task automatic test_misaligned();
    logic [5:0]  ops  [2] = '{6'h23, 6'h21};
    logic [31:0] adrs [2] = '{32'h11, 32'h13};
    for (int i = 0; i < 2; i++) begin
      set_in(ops[i], adrs[i], 32'h0, 1'b1, 1'b0, 1'b1, 5'd4, 2'd1);
      bus.dmem_ack = 1'b0;
      #1;
      checks++; if (bus.dmem_req !== 1'b0 || bus.mem_stall !== 1'b0)
        begin errors++; $display("FAIL misal%0d_req: req=%b stall=%b want 0/0", i, bus.dmem_req, bus.mem_stall); end
      step();
      checks++; if (bus.wb_addrErr !== 1'b1 || bus.wb_rfWE !== 1'b0 || bus.wb_memOut !== 32'h0 || bus.wb_busErr !== 1'b0)
        begin errors++; $display("FAIL misal%0d_wb: addrErr=%b rfWE=%b memOut=%h busErr=%b", i, bus.wb_addrErr, bus.wb_rfWE, bus.wb_memOut, bus.wb_busErr); end
    end
  endtask

  task automatic test_timeout();
    int  n = 0;
    bit  done = 0;
    set_in(6'h23, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 5'd9, 2'd1);
    bus.dmem_ack = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      #1;
      if (bus.mem_stall === 1'b1) begin n++; @(posedge clk); #1; end
      else done = 1;
    end
    checks++; if (!done || n != 3)
      begin errors++; $display("FAIL timeout_stall: got %0d stall cycles (ended=%0d) want 3", n, done); end
    checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL timeout_abort_req: got %b want 1", bus.dmem_req); end
    step();
    checks++; if (bus.wb_busErr !== 1'b1 || bus.wb_rfWE !== 1'b0 || bus.wb_memOut !== 32'h0)
      begin errors++; $display("FAIL timeout_wb: busErr=%b rfWE=%b memOut=%h want 1/0/0", bus.wb_busErr, bus.wb_rfWE, bus.wb_memOut); end
    checks++; if (bus.wb_inst !== {6'h23, 26'h0ABCDE} || bus.wb_opResult !== 32'h20)
      begin errors++; $display("FAIL timeout_capture: inst=%h op=%h", bus.wb_inst, bus.wb_opResult); end
    set_in(6'h00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
    step();
    checks++; if (bus.wb_busErr !== 1'b0) begin errors++; $display("FAIL timeout_one_cycle: busErr=%b want 0", bus.wb_busErr); end
  endtask

  task automatic test_ack_at_timeout();
    set_in(6'h23, 32'h24, 32'h0, 1'b1, 1'b0, 1'b1, 5'd11, 2'd0);
    bus.dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.mem_stall !== 1'b1) begin errors++; $display("FAIL acktmo%0d_stall: got %b want 1", i, bus.mem_stall); end
      @(posedge clk); #1;
    end
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1234_5678;
    #1;
    checks++; if (bus.mem_stall !== 1'b0) begin errors++; $display("FAIL acktmo_stall_last: got %b want 0", bus.mem_stall); end
    step();
    checks++; if (bus.wb_busErr !== 1'b0 || bus.wb_memOut !== 32'h1234_5678 || bus.wb_rfWE !== 1'b1)
      begin errors++; $display("FAIL acktmo_wb: busErr=%b memOut=%h rfWE=%b want 0/12345678/1", bus.wb_busErr, bus.wb_memOut, bus.wb_rfWE); end
    bus.dmem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int n = 0;
    bit done = 0;
    set_in(6'h23, 32'h30, 32'h0, 1'b1, 1'b0, 1'b1, 5'd2, 2'd1);
    bus.dmem_ack = 1'b0;
    step(); step();
    rst = 1'b1;
    #1;
    checks++; if (bus.dmem_req !== 1'b0 || bus.mem_stall !== 1'b0)
      begin errors++; $display("FAIL rstwait_req: req=%b stall=%b want 0/0", bus.dmem_req, bus.mem_stall); end
    step();
    checks++; if (bus.wb_inst !== 32'h0 || bus.wb_rfWE !== 1'b0 || bus.wb_busErr !== 1'b0 || bus.wb_opResult !== 32'h0)
      begin errors++; $display("FAIL rstwait_wb: inst=%h rfWE=%b busErr=%b want 0", bus.wb_inst, bus.wb_rfWE, bus.wb_busErr); end
    rst = 1'b0;
    set_in(6'h00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h5555_5555;
    #1;
    checks++; if (bus.dmem_req !== 1'b0 || bus.mem_stall !== 1'b0)
      begin errors++; $display("FAIL stray_ack_req: req=%b stall=%b want 0/0", bus.dmem_req, bus.mem_stall); end
    step();
    checks++; if (bus.wb_memOut !== 32'h0) begin errors++; $display("FAIL stray_ack_memOut: got %h want 0", bus.wb_memOut); end
    bus.dmem_ack = 1'b0;
    set_in(6'h23, 32'h34, 32'h0, 1'b1, 1'b0, 1'b1, 5'd2, 2'd1);
    for (int i = 0; i < 10 && !done; i++) begin
      #1;
      if (bus.mem_stall === 1'b1) begin n++; @(posedge clk); #1; end
      else done = 1;
    end
    checks++; if (!done || n != 3)
      begin errors++; $display("FAIL rstwait_fresh_cnt: got %0d stall cycles want 3", n); end
    step();
    set_in(6'h00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
    step();
  endtask

  task automatic test_passthrough();
    set_in(6'h00, 32'hCAFE_0000, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 2'd2);
    bus.dmem_ack = 1'b0;
    #1;
    checks++; if (bus.dmem_req !== 1'b0 || bus.mem_stall !== 1'b0)
      begin errors++; $display("FAIL pass_req: req=%b stall=%b want 0/0", bus.dmem_req, bus.mem_stall); end
    step();
    checks++; if (bus.wb_opResult !== 32'hCAFE_0000 || bus.wb_rfDst !== 5'd5 || bus.wb_rfSrc !== 2'd2 ||
                  bus.wb_rfWE !== 1'b1 || bus.wb_memOut !== 32'h0)
      begin errors++; $display("FAIL pass_wb: op=%h dst=%0d src=%0d rfWE=%b memOut=%h", bus.wb_opResult, bus.wb_rfDst, bus.wb_rfSrc, bus.wb_rfWE, bus.wb_memOut); end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops  [3] = '{6'h23, 6'h24, 6'h25};
    logic [31:0] adrs [3] = '{32'h40, 32'h41, 32'h42};
    logic [31:0] rds  [3] = '{32'h0000_000A, 32'h0000_5500, 32'hBEEF_0000};
    logic [31:0] exps [3] = '{32'h0000_000A, 32'h0000_0055, 32'h0000_BEEF};
    for (int i = 0; i < 3; i++) begin
      set_in(ops[i], adrs[i], 32'h0, 1'b1, 1'b0, 1'b1, 5'd8, 2'd0);
      bus.dmem_ack = 1'b1; bus.dmem_rdata = rds[i];
      step();
      checks++; if (bus.wb_memOut !== exps[i] || bus.wb_opResult !== adrs[i])
        begin errors++; $display("FAIL b2b%0d: memOut=%h op=%h want %h/%h", i, bus.wb_memOut, bus.wb_opResult, exps[i], adrs[i]); end
    end
    bus.dmem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_store();
    test_wait_load();
    test_misaligned();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_wait();
    test_passthrough();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
